// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl: fetches three image rows from BRAM into byte-granular row FIFOs and
// pops them in lockstep to stream valid-mode 3x3 windows in raster order, one frame per start.
`timescale 1ns/1ps

module window_fetch_ctrl #(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              enb_o,
  output logic [ADDR_W-1:0] addrb_o,
  input  logic [63:0]       doutb_i,
  output logic [2:0]        fifo_push_o,
  output logic [63:0]       fifo_din_o,
  output logic              fifo_pop_o,
  output logic              row_clear_o,
  input  logic [23:0]       fifo_dout0_i,
  input  logic [23:0]       fifo_dout1_i,
  input  logic [23:0]       fifo_dout2_i,
  output logic [71:0]       window_data_o,
  output logic              window_valid_o,
  input  logic              window_ready_i
);

  localparam int unsigned WPR   = IMG_W / 8;
  localparam int unsigned WordW = $clog2(WPR + 1);
  localparam int unsigned ColW  = $clog2(IMG_W);
  localparam int unsigned RowW  = $clog2(IMG_H);

  localparam logic [WordW-1:0] LastWord = WordW'(WPR);
  localparam logic [ColW-1:0]  LastCol  = ColW'(IMG_W - 3);
  localparam logic [RowW-1:0]  LastRow  = RowW'(IMG_H - 3);

  typedef enum logic [1:0] {StIdle, StRun, StRowEnd, StFlush} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;     // output row, also base input row
  logic [ColW-1:0]   col_q, col_d;     // output column of the next pop
  logic [WordW-1:0]  word_q, word_d;   // word index of the next fetch; WPR means all fetched
  logic [1:0]        fk_q, fk_d;       // row FIFO the fetch engine is waiting on
  logic [2:0][3:0]   occ_q, occ_d;     // bytes held in each row FIFO
  logic [2:0]        push_q, push_d;   // read in flight, lands next cycle
  logic              first_q, first_d; // first RUN cycle after start
  logic [71:0]       win_q, win_d;
  logic              valid_q, valid_d;

  logic              fetch_done;
  logic              issue;
  logic              pop;
  logic [ADDR_W-1:0] addr;

  // Fetch issue, pop permission and read address for the current cycle.
  always_comb begin
    fetch_done = (word_q == LastWord);
    issue      = (state_q == StRun) && !fetch_done && (occ_q[fk_q] <= 4'd7) && !push_q[fk_q];
    pop        = (state_q == StRun) && (occ_q[0] >= 4'd3) && (occ_q[1] >= 4'd3) &&
                 (occ_q[2] >= 4'd3) && (!valid_q || window_ready_i);
    addr       = ADDR_W'((32'(row_q) + 32'(fk_q)) * WPR + 32'(word_q));
  end

  // Next-state logic: FSM, fetch round-robin, FIFO occupancy and output register.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    word_d  = word_q;
    fk_d    = fk_q;
    push_d  = '0;
    first_d = 1'b0;
    win_d   = win_q;
    valid_d = valid_q;
    occ_d   = occ_q;

    for (int k = 0; k < 3; k++) begin
      case ({push_q[k], pop})
        2'b10:   occ_d[k] = occ_q[k] + 4'd8;
        2'b01:   occ_d[k] = occ_q[k] - 4'd1;
        2'b11:   occ_d[k] = occ_q[k] + 4'd7;
        default: occ_d[k] = occ_q[k];
      endcase
    end

    if (pop) begin
      win_d   = {fifo_dout2_i, fifo_dout1_i, fifo_dout0_i};
      valid_d = 1'b1;
    end else if (window_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          first_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          word_d  = '0;
          fk_d    = '0;
          occ_d   = '0;
        end
      end
      StRun: begin
        if (issue) begin
          push_d[fk_q] = 1'b1;
          if (fk_q == 2'd2) begin
            fk_d   = 2'd0;
            word_d = word_q + WordW'(1);
          end else begin
            fk_d = fk_q + 2'd1;
          end
        end
        if (pop) begin
          col_d = col_q + ColW'(1);
          if (col_q == LastCol) begin
            state_d = StRowEnd;
          end
        end
      end
      StRowEnd: begin
        // The two residual bytes per FIFO are dropped; the next row refetches all three rows.
        occ_d   = '0;
        col_d   = '0;
        word_d  = '0;
        fk_d    = '0;
        row_d   = row_q + RowW'(1);
        state_d = (row_q == LastRow) ? StFlush : StRun;
      end
      StFlush: begin
        if (!valid_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      word_q  <= '0;
      fk_q    <= '0;
      occ_q   <= '0;
      push_q  <= '0;
      first_q <= 1'b0;
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      word_q  <= word_d;
      fk_q    <= fk_d;
      occ_q   <= occ_d;
      push_q  <= push_d;
      first_q <= first_d;
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  // Outputs; done is the FLUSH cycle with an empty output register, busy drops with it.
  always_comb begin
    done_o         = (state_q == StFlush) && !valid_q;
    busy_o         = (state_q != StIdle) && !done_o;
    enb_o          = issue;
    addrb_o        = issue ? addr : '0;
    fifo_push_o    = push_q;
    // BRAM output is already registered; gate it so the bus is quiet between pushes.
    fifo_din_o     = (|push_q) ? doutb_i : '0;
    fifo_pop_o     = pop;
    row_clear_o    = first_q || (state_q == StRowEnd);
    window_data_o  = win_q;
    window_valid_o = valid_q;
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl: instance 0 uses the default 16x16 geometry, instance 1 is 8x3.
// BRAM and row FIFOs are modelled here; windows and read addresses come from image arithmetic.
`timescale 1ns/1ps

module tb_window_fetch_ctrl;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start [NI];
  logic        busy [NI];
  logic        done [NI];
  logic        enb [NI];
  logic [7:0]  addrb [NI];
  logic [63:0] doutb [NI];
  logic [2:0]  fifo_push [NI];
  logic [63:0] fifo_din [NI];
  logic        fifo_pop [NI];
  logic        row_clear [NI];
  logic [23:0] fdout [NI][3];
  logic [71:0] wdata [NI];
  logic        wvalid [NI];
  logic        wready [NI];

  logic [63:0] mem [NI][256];
  logic [7:0]  fq [NI][3][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          win_cnt [NI];
  int          clr_cnt [NI];
  int          done_cnt [NI];
  int          addr_cnt [NI];
  int          last_acc [NI];
  logic        hold_prev [NI];
  logic [71:0] data_prev [NI];
  logic [71:0] first_win [NI];
  logic [71:0] last_win [NI];

  logic        s_enb [NI];
  logic [7:0]  s_addr [NI];
  logic [2:0]  s_push [NI];
  logic [63:0] s_din [NI];
  logic        s_pop [NI];
  logic        s_clr [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned W = (g == 0) ? 16 : 8;
    localparam int unsigned H = (g == 0) ? 16 : 3;
    window_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(8)) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start_i        (start[g]),
      .busy_o         (busy[g]),
      .done_o         (done[g]),
      .enb_o          (enb[g]),
      .addrb_o        (addrb[g]),
      .doutb_i        (doutb[g]),
      .fifo_push_o    (fifo_push[g]),
      .fifo_din_o     (fifo_din[g]),
      .fifo_pop_o     (fifo_pop[g]),
      .row_clear_o    (row_clear[g]),
      .fifo_dout0_i   (fdout[g][0]),
      .fifo_dout1_i   (fdout[g][1]),
      .fifo_dout2_i   (fdout[g][2]),
      .window_data_o  (wdata[g]),
      .window_valid_o (wvalid[g]),
      .window_ready_i (wready[g])
    );
  end

  function automatic int img_w(input int g);
    return (g == 0) ? 16 : 8;
  endfunction

  function automatic int img_h(input int g);
    return (g == 0) ? 16 : 3;
  endfunction

  function automatic int total_win(input int g);
    return (img_h(g) - 2) * (img_w(g) - 2);
  endfunction

  function automatic int total_reads(input int g);
    return (img_h(g) - 2) * 3 * (img_w(g) / 8);
  endfunction

  function automatic logic [7:0] pix(input int g, input int row, input int col);
    logic [63:0] wd;
    wd = mem[g][row * (img_w(g) / 8) + col / 8];
    return wd[8 * (col % 8) +: 8];
  endfunction

  // Window n of the frame in raster order, built straight from the image.
  function automatic logic [71:0] exp_window(input int g, input int n);
    logic [71:0] res;
    int wr, r, c;
    wr  = img_w(g) - 2;
    r   = n / wr;
    c   = n % wr;
    res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[24 * i + 8 * j +: 8] = pix(g, r + i, c + j);
    return res;
  endfunction

  // Read n of the frame: output row r needs input rows r..r+2, word-major, row-minor.
  function automatic logic [7:0] exp_addr(input int g, input int n);
    int wpr, r, rem, w, k;
    wpr = img_w(g) / 8;
    r   = n / (3 * wpr);
    rem = n % (3 * wpr);
    w   = rem / 3;
    k   = rem % 3;
    return 8'((r + k) * wpr + w);
  endfunction

  initial begin
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      wready[g] = 1'b0;
      doutb[g] = '0;
      s_enb[g] = 1'b0; s_addr[g] = '0; s_push[g] = '0; s_din[g] = '0;
      s_pop[g] = 1'b0; s_clr[g] = 1'b0;
      hold_prev[g] = 1'b0; data_prev[g] = '0;
      win_cnt[g] = 0; clr_cnt[g] = 0; done_cnt[g] = 0; addr_cnt[g] = 0; last_acc[g] = -10;
      for (int k = 0; k < 3; k++) fdout[g][k] = '0;
    end
  end

  // BRAM (1-cycle latency) and row FIFO models, applying the events seen in the last cycle.
  always @(posedge clk) begin
    logic [23:0] head;
    cyc++;
    for (int g = 0; g < NI; g++) begin
      if (s_enb[g]) doutb[g] <= mem[g][s_addr[g]];
      for (int k = 0; k < 3; k++) begin
        if (s_clr[g]) fq[g][k].delete();
        if (s_pop[g] && fq[g][k].size() > 0) void'(fq[g][k].pop_front());
        if (s_push[g][k])
          for (int b = 0; b < 8; b++) fq[g][k].push_back(s_din[g][8 * b +: 8]);
        head = '0;
        for (int b = 0; b < 3; b++)
          if (b < fq[g][k].size()) head[8 * b +: 8] = fq[g][k][b];
        fdout[g][k] <= head;
      end
    end
  end

  // Mid-cycle monitor: protocol rules, address order and window stream against the model.
  always @(negedge clk) begin
    logic [7:0] ea;
    logic [71:0] ew;
    for (int g = 0; g < NI; g++) begin
      if (reset_n !== 1'b1) begin
        s_enb[g] = 1'b0; s_push[g] = '0; s_pop[g] = 1'b0; s_clr[g] = 1'b0;
        hold_prev[g] = 1'b0;
        continue;
      end
      s_enb[g]  = enb[g];
      s_addr[g] = addrb[g];
      s_push[g] = fifo_push[g];
      s_din[g]  = fifo_din[g];
      s_pop[g]  = fifo_pop[g];
      s_clr[g]  = row_clear[g];

      if (fifo_pop[g] === 1'b1) begin
        checks++;
        if (fq[g][0].size() < 3 || fq[g][1].size() < 3 || fq[g][2].size() < 3) begin
          errors++;
          $display("FAIL fifo_underflow[%0d]: occupancy %0d/%0d/%0d at pop, need >= 3", g,
                   fq[g][0].size(), fq[g][1].size(), fq[g][2].size());
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (fifo_push[g][k] === 1'b1) begin
          checks++;
          if (fq[g][k].size() - int'(fifo_pop[g]) + 8 > 15) begin
            errors++;
            $display("FAIL occupancy[%0d] row %0d: would hold %0d bytes, max 15", g, k,
                     fq[g][k].size() - int'(fifo_pop[g]) + 8);
          end
        end
      end
      if (enb[g] === 1'b1) begin
        checks++;
        ea = exp_addr(g, addr_cnt[g]);
        if (addr_cnt[g] >= total_reads(g) || addrb[g] !== ea) begin
          errors++;
          $display("FAIL addrb[%0d] read %0d: got %0d expected %0d", g, addr_cnt[g], addrb[g], ea);
        end
        addr_cnt[g]++;
      end
      if (hold_prev[g]) begin
        checks++;
        if (wvalid[g] !== 1'b1 || wdata[g] !== data_prev[g]) begin
          errors++;
          $display("FAIL hold_stable[%0d]: got valid=%b data=%h expected valid=1 data=%h", g,
                   wvalid[g], wdata[g], data_prev[g]);
        end
      end
      if (wvalid[g] === 1'b1 && wready[g] === 1'b0) begin
        checks++;
        if (fifo_pop[g] !== 1'b0) begin
          errors++;
          $display("FAIL pop_while_full[%0d]: fifo_pop=%b expected 0", g, fifo_pop[g]);
        end
      end
      hold_prev[g] = (wvalid[g] === 1'b1) && (wready[g] === 1'b0);
      data_prev[g] = wdata[g];
      if (wvalid[g] === 1'b1 && wready[g] === 1'b1) begin
        checks++;
        ew = (win_cnt[g] < total_win(g)) ? exp_window(g, win_cnt[g]) : '0;
        if (win_cnt[g] >= total_win(g) || wdata[g] !== ew) begin
          errors++;
          $display("FAIL window[%0d] #%0d: got %h expected %h", g, win_cnt[g], wdata[g], ew);
        end
        if (win_cnt[g] == 0) first_win[g] = wdata[g];
        last_win[g] = wdata[g];
        win_cnt[g]++;
        last_acc[g] = cyc;
      end
      if (row_clear[g] === 1'b1) clr_cnt[g]++;
      if (done[g] === 1'b1) begin
        checks++;
        done_cnt[g]++;
        if (cyc != last_acc[g] + 1 || busy[g] !== 1'b0) begin
          errors++;
          $display("FAIL done_timing[%0d]: done at cycle %0d busy=%b, expected cycle %0d busy=0",
                   g, cyc, busy[g], last_acc[g] + 1);
        end
      end
    end
  end

  task automatic clear_counts(input int g);
    win_cnt[g] = 0; clr_cnt[g] = 0; done_cnt[g] = 0; addr_cnt[g] = 0; last_acc[g] = -10;
  endtask

  // One frame on instance g. mode 0: ready high; mode 1: ready low 10 cycles then 50% random.
  task automatic run_frame(input int g, input int mode, input int mid_start, input bit timing,
                           input bit start_in_done, input string name);
    int t;
    bit seen;
    clear_counts(g);
    @(posedge clk); #1;
    start[g] = 1'b1;
    wready[g] = (mode == 0);
    @(posedge clk); #1;
    start[g] = 1'b0;
    t = 1;
    seen = 1'b0;
    while (!seen && t < 5000) begin
      @(negedge clk);
      if (timing) begin
        checks += (t <= 6) ? 1 : 0;
        case (t)
          1: if ({busy[g], row_clear[g], enb[g], addrb[g]} !== {3'b111, 8'd0}) begin
               errors++;
               $display("FAIL %s cycle1: busy/clr/enb/addr=%b%b%b/%0d expected 111/0", name,
                        busy[g], row_clear[g], enb[g], addrb[g]);
             end
          2: if ({enb[g], addrb[g], fifo_push[g]} !== {1'b1, 8'd2, 3'b001}) begin
               errors++;
               $display("FAIL %s cycle2: enb=%b addr=%0d push=%b expected 1/2/001", name,
                        enb[g], addrb[g], fifo_push[g]);
             end
          3: if ({enb[g], addrb[g], fifo_push[g]} !== {1'b1, 8'd4, 3'b010}) begin
               errors++;
               $display("FAIL %s cycle3: enb=%b addr=%0d push=%b expected 1/4/010", name,
                        enb[g], addrb[g], fifo_push[g]);
             end
          4: if (fifo_push[g] !== 3'b100) begin
               errors++;
               $display("FAIL %s cycle4: push=%b expected 100", name, fifo_push[g]);
             end
          5: if ({fifo_pop[g], wvalid[g]} !== 2'b10) begin
               errors++;
               $display("FAIL %s cycle5: pop/valid=%b%b expected 10", name, fifo_pop[g], wvalid[g]);
             end
          6: if (wvalid[g] !== 1'b1) begin
               errors++;
               $display("FAIL %s cycle6: valid=%b expected 1", name, wvalid[g]);
             end
          default: ;
        endcase
      end
      if (done[g] === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        start[g] = (t + 1 == mid_start);
        if (mode == 0) wready[g] = 1'b1;
        else wready[g] = (t + 1 <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
        t++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s frame_timeout: no done after %0d cycles, expected done", name, t);
    end
    // Still in the done cycle: a start here must be ignored.
    start[g] = start_in_done;
    @(posedge clk); #1;
    start[g] = 1'b0;
    wready[g] = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy[g], done[g], enb[g]} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_done: busy/done/enb=%b%b%b expected 000", name, busy[g], done[g],
               enb[g]);
    end
    @(posedge clk); #1;
    checks++;
    if (win_cnt[g] != total_win(g) || clr_cnt[g] != img_h(g) - 1 ||
        addr_cnt[g] != total_reads(g) || done_cnt[g] != 1) begin
      errors++;
      $display("FAIL %s counts: win=%0d clr=%0d reads=%0d done=%0d expected %0d/%0d/%0d/1", name,
               win_cnt[g], clr_cnt[g], addr_cnt[g], done_cnt[g], total_win(g), img_h(g) - 1,
               total_reads(g));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        start[g] = 1'($urandom);
        wready[g] = 1'($urandom);
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        checks++;
        if ({busy[g], done[g], enb[g], addrb[g], fifo_push[g], fifo_din[g], fifo_pop[g],
             row_clear[g], wdata[g], wvalid[g]} !== '0) begin
          errors++;
          $display("FAIL reset_outputs[%0d]: some output nonzero (busy=%b enb=%b data=%h), expected 0",
                   g, busy[g], enb[g], wdata[g]);
        end
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      wready[g] = 1'b0;
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (busy[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_busy[%0d]: got %b expected 0", g, busy[g]);
      end
    end
  endtask

  task automatic test_small();
    for (int r = 0; r < 3; r++) begin
      logic [63:0] wd;
      for (int c = 0; c < 8; c++) wd[8 * c +: 8] = 8'(16 * r + c);
      mem[1][r] = wd;
    end
    run_frame(1, 0, 0, 0, 0, "small");
    checks++;
    if (first_win[1] !== 72'h222120_121110_020100) begin
      errors++;
      $display("FAIL small_first: got %h expected 222120121110020100", first_win[1]);
    end
    checks++;
    if (last_win[1] !== 72'h272625_171615_070605) begin
      errors++;
      $display("FAIL small_last: got %h expected 272625171615070605", last_win[1]);
    end
  endtask

  task automatic test_defaults();
    for (int i = 0; i < 32; i++) mem[0][i] = {$urandom, $urandom};
    run_frame(0, 0, 0, 1, 0, "defaults");
  endtask

  task automatic test_backpressure();
    run_frame(0, 1, 0, 0, 0, "backpressure");
  endtask

  task automatic test_start_busy();
    run_frame(0, 0, 40, 0, 1, "start_busy");
    run_frame(0, 0, 0, 1, 0, "restart");
  endtask

  task automatic test_mid_reset();
    clear_counts(0);
    @(posedge clk); #1;
    start[0] = 1'b1;
    wready[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy[0], done[0], enb[0], addrb[0], fifo_push[0], fifo_din[0], fifo_pop[0],
         row_clear[0], wdata[0], wvalid[0]} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b enb=%b push=%b valid=%b data=%h expected all 0",
               busy[0], enb[0], fifo_push[0], wvalid[0], wdata[0]);
    end
    run_frame(0, 0, 0, 1, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_small();
    test_defaults();
    test_backpressure();
    test_start_busy();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_fetch_ctrl.md
# window_fetch_ctrl

Sequencer for the input layer's 3x3 window path. It reads 8-pixel (64-bit) words of an 8-bit greyscale image from block RAM port B and pushes them into three external row FIFOs (top, middle, bottom row; 15-byte, byte-granular pop). It pops the three FIFOs in lockstep and registers each 3x3 window onto a valid/ready stream for the processing stage. One start runs one frame of valid-mode windows: (IMG_H-2) x (IMG_W-2) windows in raster order.

## Interface
- IMG_W, 16, pixels per row; multiple of 8, >= 8; WPR = IMG_W/8 words per row
- IMG_H, 16, rows per frame, >= 3
- ADDR_W, 8, BRAM address width; IMG_H*WPR <= 2^ADDR_W
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  frame start; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last window is accepted
- enb  out  1  BRAM port-B read enable
- addrb  out  ADDR_W  BRAM read address; row r, word w at r*WPR+w
- doutb  in  64  BRAM read data, valid the cycle after enb; pixel 0 in [7:0]
- fifo_push  out  3  one-hot push, bit k = row FIFO k (0 = top)
- fifo_din  out  64  push data (registered doutb), shared by all three FIFOs
- fifo_pop  out  1  pops one byte from all three FIFOs
- row_clear  out  1  one-cycle clear of all three FIFOs
- fifo_dout0/1/2  in  24 each  head 3 bytes of FIFO k, oldest pixel in [7:0]
- window_data  out  72  {bottom, middle, top}; [23:0] top row, [7:0] leftmost pixel
- window_valid  out  1  window_data holds a window
- window_ready  in  1  consumer accepts when valid & ready

## Operation
- FSM: IDLE -> RUN on start. RUN -> ROW_END after the pop of column IMG_W-3. ROW_END -> RUN when more output rows remain, else -> FLUSH. FLUSH -> IDLE once the output register is empty; done pulses on that transition.
- ROW_END lasts 1 cycle. It asserts row_clear, zeroes occupancies and column counter, and increments output row r. Row_clear also pulses in the first RUN cycle after start.
- Fetch engine (RUN only): strict round-robin k = 0,1,2 within word w, then w+1, for w = 0..WPR-1. Read address is (r+k)*WPR+w, truncated to ADDR_W.
- Row k's read issues only if occ_k <= 7 and no read to row k is in flight. Otherwise the engine stalls on k; no skipping ahead.
- Push on the cycle after issue: fifo_push[k]=1, fifo_din=doutb.
- occ_k is a 4-bit count of bytes held in FIFO k: +8 on push, -1 on pop, +7 on simultaneous push and pop. It never exceeds 15.
- Pop when the FSM is in RUN, all occ_k >= 3, and the output register is empty or (window_valid & window_ready).
- On pop, {fifo_dout2, fifo_dout1, fifo_dout0} is captured into window_data, and the column counter increments (0..IMG_W-3).
- After the last pop of a row, each FIFO holds 2 residual bytes. ROW_END discards them. No line reuse: every output row refetches 3 rows.
- The output register is a single stage. window_data is held stable while valid & !ready.
- start is ignored while busy.
- Reset (any cycle, including mid-frame): FSM to IDLE, all counters and occupancies 0, in-flight reads dropped.

## Timing
- Reset value of every output is 0: busy, done, enb, addrb, fifo_push, fifo_din, fifo_pop, row_clear, window_data, window_valid.
- start high at edge E0. Cycle 1: busy=1, row_clear=1, enb=1, addrb=0. Cycle 2: addrb=WPR, fifo_push=001. Cycle 3: addrb=2*WPR, fifo_push=010. Cycle 4: fifo_push=100.
- Cycle 5: first fifo_pop. Cycle 6: first window_valid. Start-to-valid latency is 6 cycles.
- With window_ready held high, at most one window per cycle. Bubbles due to fetch stalls are permitted; lost or duplicated windows are not.
- done is asserted the cycle after the final valid & ready handshake; busy falls in the same cycle.
- A start sampled in the done cycle is ignored. A start in a later IDLE cycle begins a new frame.

## Test plan
The bench models three 15-byte row FIFOs and a BRAM with 1-cycle read latency.
- Reset: hold reset_n low 3 cycles with random inputs -> all outputs 0, busy 0 after release.
- IMG_W=8, IMG_H=3, pixel = 16*row+col, ready=1 -> 6 windows.
  - First window: window_data = 0x222120_121110_020100.
  - Last window: window_data = 0x272625_171615_070605.
  - done pulses one cycle after the 6th accept.
- Defaults, ready=1:
  - addrb sequence starts 0,2,4.
  - 196 windows in raster order.
  - row_clear pulses 15 times (1 at start + 14 ROW_END).
  - Exactly one done pulse.
- Backpressure: defaults, ready low 10 cycles then random 50% ->
  - window_data stable while valid & !ready.
  - No fifo_pop while the output register is full and ready=0.
  - occ_k never exceeds 15.
  - Same 196-window stream as the ready=1 run.
- start pulsed while busy mid-frame -> ignored; window count and addresses unchanged. start after done -> new frame; addrb restarts at 0.
- reset_n low for 1 cycle at cycle 50 of a default frame -> all outputs 0 on the next edge. Subsequent start yields the full 196-window frame from the first window.
